// File: rtl/output_delta_buffer.sv
// Output-layer delta generator: computes del = (a - y) * adot per lane in fixed point,
// buffers one full layer of beats, then streams them back out in arrival order.
module output_delta_buffer #(
   parameter int n         = 8,
   parameter int z         = 8,
   parameter int fi        = 4,
   parameter int width     = 16,
   parameter int int_bits  = 5,
   parameter int frac_bits = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [width*(z/fi)-1:0]   act_in_package,
   input  logic [width*(z/fi)-1:0]   adot_in_package,
   input  logic [(z/fi)-1:0]         ideal_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [width*(z/fi)-1:0]   del_out_package,
   output logic                      out_last,
   output logic                      busy
);

   localparam int P  = z / fi;
   localparam int B  = n / P;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam logic [CW-1:0] LAST = CW'(B - 1);

   localparam logic signed [width:0] ONE  = (width+1)'(1) << frac_bits;
   localparam logic signed [width:0] ZERO = '0;
   localparam logic signed [2*width+1:0] SMAX = {{(width+3){1'b0}}, {(width-1){1'b1}}};
   localparam logic signed [2*width+1:0] SMIN = {{(width+3){1'b1}}, {(width-1){1'b0}}};
   localparam logic [width-1:0] MAXV = {1'b0, {(width-1){1'b1}}};
   localparam logic [width-1:0] MINV = {1'b1, {(width-1){1'b0}}};

   if (width != 1 + int_bits + frac_bits) begin : g_bad_fmt
      $error("width must equal 1 + int_bits + frac_bits");
   end
   if (n % P != 0) begin : g_bad_n
      $error("n must be a multiple of z/fi");
   end

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          wr_q, wr_d;
   logic [CW-1:0]          rd_q, rd_d;
   logic                   wr_en;
   logic [P-1:0][width-1:0] lane_del;
   logic [width*P-1:0]     buf_q [B];

   // Per-lane datapath: floor shift of the full product, then clamp to the word range.
   for (genvar k = 0; k < P; k++) begin : g_lane
      logic signed [width:0]       diff;
      logic signed [2*width+1:0]   prod;
      logic signed [2*width+1:0]   q;

      assign diff = $signed({1'b0, act_in_package[width*k +: width]}) - (ideal_in[k] ? ONE : ZERO);
      assign prod = diff * $signed({1'b0, adot_in_package[width*k +: width]});
      assign q    = prod >>> frac_bits;
      assign lane_del[k] = (q > SMAX) ? MAXV :
                           (q < SMIN) ? MINV : q[width-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // Buffer contents need no reset; the counters alone decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) buf_q[wr_q] <= lane_del;
   end

   always_comb begin
      state_d         = state_q;
      wr_d            = wr_q;
      rd_d            = rd_q;
      wr_en           = 1'b0;
      in_ready        = 1'b0;
      out_valid       = 1'b0;
      out_last        = 1'b0;
      busy            = 1'b0;
      del_out_package = '0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_q == LAST) begin
                  wr_d    = '0;
                  state_d = DRAIN;
               end else begin
                  wr_d = wr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            busy            = 1'b1;
            out_valid       = 1'b1;
            del_out_package = buf_q[rd_q];
            out_last        = (rd_q == LAST);
            if (out_ready) begin
               if (rd_q == LAST) begin
                  rd_d    = '0;
                  state_d = FILL;
               end else begin
                  rd_d = rd_q + 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

endmodule

// File: doc/output_delta_buffer.md
Name: output_delta_buffer

Overview:
Output-layer delta generator and buffer. It is the producer end of the del_in stream that the backpropagation and update processor sets consume.
- Takes output-layer activations, activation derivatives and ideal outputs from the last feedforward processor set, z/fi neurons per beat.
- Computes del = (a - y) * adot in fixed point and buffers a full layer of n deltas.
- Streams the deltas back out, z/fi per beat, in the same order, as del_in_package beats.

Parameters:
n, 8, neurons in output layer; must be a multiple of P.
z, 8, weights processed per cycle.
fi, 4, fan-in; P = z/fi neurons per beat, B = n/P beats per layer.
width, 16, data word width (signed fixed point, 1 sign + int_bits + frac_bits).
int_bits, 5, integer bits.
frac_bits, 10, fractional bits; 1.0 = 2^frac_bits.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts input beat
act_in_package  in  width*P  P activations a, unsigned, lane k at bits [width*(k+1)-1 : width*k]
adot_in_package  in  width*P  P derivatives adot, unsigned, same lane packing
ideal_in  in  P  ideal outputs y, one bit per lane; 1 means 1.0, 0 means 0
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
del_out_package  out  width*P  P signed deltas, same lane packing
out_last  out  1  high on the final (B-th) output beat of a layer
busy  out  1  high while in DRAIN

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high. A single reset clears the whole block; nothing resets asynchronously.
- Reset values: state=FILL, write count=0, read count=0, in_ready=1, out_valid=0, out_last=0, busy=0, del_out_package=0. Buffer contents are don't-care after reset.
- Reset mid-operation (FILL or DRAIN) discards all buffered beats. The next cycle is in FILL with both counters at 0.
- State machine:
  - FILL: in_ready=1, out_valid=0.
    - An input handshake (in_valid & in_ready) stores the P computed deltas at buffer[write count] and increments write count.
    - On the handshake with write count = B-1, go to DRAIN and clear write count.
  - DRAIN: in_ready=0, busy=1. in_valid is ignored and no input is stored.
    - out_valid=1 and del_out_package = buffer[read count].
    - out_last=1 when read count = B-1.
    - On an output handshake (out_valid & out_ready), increment read count.
    - On the handshake with read count = B-1, go to FILL and clear read count.
- Latency:
  - First out_valid is asserted the cycle after the B-th input handshake.
  - With out_ready held high, B output beats follow on consecutive cycles.
  - in_ready returns to 1 the cycle after the out_last handshake.
- Backpressure: while out_valid=1 and out_ready=0, del_out_package, out_last and read count hold stable.
- Ordering: output beat j equals input beat j, lane for lane.
- Arithmetic, per lane, computed at input and stored:
  - yv = y ? 2^frac_bits : 0.
  - diff = a - yv, signed width+1 bits; a is zero-extended.
  - prod = diff * adot, signed 2*width+1 bits; adot is zero-extended.
  - q = prod >>> frac_bits, an arithmetic shift, i.e. floor.
  - del = q saturated to the signed width range: q > 2^(width-1)-1 gives 0x7FFF..., q < -2^(width-1) gives 0x8000....
- Sizing: the buffer is B entries of width*P bits. With defaults, B = 4 and entries are 32 bits.

Test Plan:
- Exact math, lane 0: a=768 (0.75), y=1, adot=192 -> del=-48 (0xFFD0). Lane 1: a=512, y=0, adot=256 -> del=128 (0x0080).
- Floor and saturation: a=1023, y=1, adot=1024 -> del=-1 (0xFFFF). a=0x7FFF, y=0, adot=0x7FFF -> del=0x7FFF.
- Full layer, defaults (B=4), in_valid high on 4 consecutive cycles:
  - in_ready drops the cycle after the 4th accept; out_valid rises the same cycle.
  - Beats 0..3 come out in order with out_ready=1; out_last is high only on beat 3.
  - in_ready is 1 again the next cycle.
- Backpressure: hold out_ready=0 for 3 cycles at beat 1 -> del_out_package and out_last stay stable. in_valid pulses during DRAIN are not accepted. The total output count stays 4.
- Input gaps: in_valid toggles 1,0,0,1,1,0,1 -> exactly 4 accepts and DRAIN entry only after the 4th.
- Reset mid-DRAIN after 2 output beats: next cycle out_valid=0, in_ready=1, busy=0. A following 4-beat layer drains exactly its own data, with no stale beats.
